lc3_ctrl_seq: RTL
=================

Name: lc3_ctrl_seq

Overview:
- Parametrised second-generation LC-3 control sequencer. Drives the datapath through one packed control word.
- Waits on memory in one of two modes: a READY handshake or a fixed latency.
- Detects bus timeouts and illegal opcodes, and counts retired instructions.
- Sits between the IR/CC registers and the datapath muxes, gates and load enables.

Parameters:
- MEM_MODE, 0: 0 = wait for READY; 1 = fixed latency, READY ignored.
- MEM_LAT, 2: cycles per memory access in mode 1; must be ≥1.
- TIMEOUT, 255: max wait cycles in mode 0; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous active-high reset
- READY  in  1  memory access complete (mode 0)
- IR  in  16  instruction register
- N, Z, P  in  1 each  condition codes
- CTRL  out  25  control word: [0]LD_MAR [1]LD_MDR [2]LD_IR [3]LD_PC [4]LD_REG [5]LD_BEN [6]LD_CC [7]GateMARMUX [8]GateMDR [9]GateALU [10]GatePC [11]MARMUXsel [12]ADDR1MUXsel [14:13]ADDR2MUXsel [16:15]PCMUXsel [18:17]SR1MUXsel [19]CS [20]WE [22:21]ALUK [24:23]DRMUXsel
- STATE  out  6  current state code
- INSTR_DONE  out  1  one-cycle pulse when an instruction retires
- BUS_ERR  out  1  one-cycle pulse on timeout
- ILL_OP  out  1  one-cycle pulse on illegal opcode
- ERR_STICKY  out  1  set by BUS_ERR or ILL_OP; cleared only by RESET
- INSTRET  out  CNT_W  retired-instruction count

Behaviour:
- Reset: state FETCH1(18); CTRL=0; pulse outputs 0; ERR_STICKY=0; INSTRET=0; wait counter 0; BEN register 0.
- Reset mid-access: drops CS/WE immediately; no retire.
- CTRL is a combinational Moore decode of the state and wait counter. All fields not listed for a state are 0.
- States, codes and CTRL assertions (ADDR1/ADDR2 = 0/2 selects PC + off9):
  - FETCH1 18: LD_MAR, GatePC, LD_PC, PCMUX=0.
  - FETCH2 33 (wait): CS; LD_MDR.
  - FETCH3 35: LD_IR, GateMDR.
  - DECODE 32: LD_BEN. BEN = IR[11]&N | IR[10]&Z | IR[9]&P is computed combinationally and registered.
  - ADD 8 / AND 5 / NOT 9: LD_REG, SR1MUX=1, GateALU, LD_CC; ALUK = 0 / 1 / 2 respectively.
  - LEA 14: LD_REG, ADDR1=0, ADDR2=2, MARMUXsel, GateMARMUX, LD_CC.
  - LD 2, LDI1 10, ST 3, STI1 11: LD_MAR, ADDR1=0, ADDR2=2, MARMUXsel, GateMARMUX.
  - LDR 6, STR 7: LD_MAR, SR1MUX=1, ADDR1=1, ADDR2=1, MARMUXsel, GateMARMUX.
  - LDI2 24, STI2 29, MEM11 25 (wait): CS; LD_MDR.
  - LDI3 26, STI3 31: GateMDR, LD_MAR.
  - MEM12 27: GateMDR, LD_REG, LD_CC.
  - MEM21 23: SR1MUX=0, ALUK=3, GateALU, LD_MDR.
  - MEM22 16 (wait): CS, WE.
  - TRAP1 15: GateMARMUX, LD_MAR.
  - TRAP2 28 (wait): CS; LD_MDR, LD_REG, DRMUX=1, GatePC.
  - TRAP3 30: GateMDR, PCMUX=1, LD_PC.
  - JSR 4: GatePC, DRMUX=1, LD_REG.
  - JSR0 20, JMP 12: SR1MUX=1, ADDR1=1, ADDR2=0, PCMUX=2, LD_PC.
  - JSR1 21: ADDR1=0, ADDR2=3, PCMUX=2, LD_PC.
  - BR2 22: ADDR1=0, ADDR2=2, PCMUX=2, LD_PC.
- Transitions:
  - FETCH1→FETCH2→FETCH3→DECODE.
  - DECODE by IR[15:12]: 1→ADD, 5→AND, 9→NOT, E→LEA, 2→LD, 6→LDR, A→LDI1, 3→ST, 7→STR, B→STI1, 4→JSR, C→JMP, F→TRAP1.
  - DECODE, opcode 0: →BR2 if combinational BEN=1, else →FETCH1 (retires).
  - DECODE, opcodes 8 and D: →FETCH1 with ILL_OP pulse; no retire.
  - LD/LDR/LDI3 → MEM11 → MEM12 → FETCH1.
  - LDI1 → LDI2 → LDI3.
  - ST/STR/STI3 → MEM21 → MEM22 → FETCH1.
  - STI1 → STI2 → STI3.
  - TRAP1 → TRAP2 → TRAP3 → FETCH1.
  - JSR → JSR1 if IR[11]=1, else JSR0; then → FETCH1.
- Wait states: counter clears on entry and increments each cycle held.
  - Mode 0: exit on the cycle READY=1 is sampled. The "(wait)" loads above (LD_MDR, LD_REG) assert only on that completion cycle; CS/WE assert every cycle.
  - Mode 1: exit after exactly MEM_LAT cycles; the loads assert on cycle MEM_LAT.
  - Timeout (mode 0, TIMEOUT>0): if the counter reaches TIMEOUT with READY=0, go to FETCH1, pulse BUS_ERR, no retire. If READY=1 arrives on the same cycle the counter reaches TIMEOUT, READY wins.
- Retire: INSTR_DONE pulses in the cycle the state transitions to FETCH1 from any non-error path. INSTRET increments the following edge and wraps modulo 2^CNT_W.

Test Plan:
- Mode 0, IR=0x1042 (ADD), READY tied 1 → FETCH1,33,35,32,8,18; one INSTR_DONE; INSTRET=1.
- Mode 0, LD, READY low for 3 cycles in MEM11 → CS held 4 cycles; LD_MDR only on the 4th; then MEM12 asserts LD_REG and LD_CC.
- Mode 1, MEM_LAT=3, STR with READY=0 → MEM22 held exactly 3 cycles with CS=WE=1; retires.
- Mode 0, TIMEOUT=4, READY never high in FETCH2 → BUS_ERR pulse; return to FETCH1; ERR_STICKY=1; INSTRET unchanged.
- BR, IR=0x0405 with Z=1 → DECODE→22 (LD_PC, PCMUX=2). With N=1 only → DECODE→18.
- IR=0xD000 → ILL_OP pulse, ERR_STICKY=1. Repeat 2^CNT_W retires with CNT_W=4 → INSTRET wraps to 0. Assert RESET mid-MEM22 → CTRL=0, state 18.

Source files
------------

// File: rtl/lc3_ctrl_seq.sv
// lc3_ctrl_seq -- LC-3 control sequencer.
//
// Walks the LC-3 instruction cycle (fetch, decode, execute, memory) and
// presents one packed control word to the datapath each cycle.
//
// Ports:
//   CLK, RESET   clock; asynchronous active-high reset
//   READY        memory access complete (used only when MEM_MODE == 0)
//   IR           instruction register contents
//   N, Z, P      condition codes
//   CTRL         25-bit control word (Moore decode of state + wait counter)
//   STATE        current state code
//   INSTR_DONE   one-cycle pulse in the cycle an instruction retires
//   BUS_ERR      one-cycle pulse when a memory wait times out
//   ILL_OP       one-cycle pulse when DECODE sees opcode 8 or D
//   ERR_STICKY   latched BUS_ERR | ILL_OP, cleared only by RESET
//   INSTRET      retired-instruction count, wraps modulo 2^CNT_W
//
// Memory handshake: in a wait state the sequencer holds CS (and WE for a
// store) every cycle. With MEM_MODE == 0 the access completes in the cycle
// READY is sampled high; with MEM_MODE == 1 it completes on the MEM_LAT-th
// cycle and READY is ignored. Loads from the bus (LD_MDR, LD_REG) assert
// only in the completion cycle.
module lc3_ctrl_seq #(
  parameter int MEM_MODE = 0,
  parameter int MEM_LAT  = 2,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             READY,
  input  logic [15:0]      IR,
  input  logic             N,
  input  logic             Z,
  input  logic             P,
  output logic [24:0]      CTRL,
  output logic [5:0]       STATE,
  output logic             INSTR_DONE,
  output logic             BUS_ERR,
  output logic             ILL_OP,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] INSTRET
);

  typedef enum logic [5:0] {
    S_FETCH1 = 6'd18, S_FETCH2 = 6'd33, S_FETCH3 = 6'd35, S_DECODE = 6'd32,
    S_ADD    = 6'd8,  S_AND    = 6'd5,  S_NOT    = 6'd9,  S_LEA    = 6'd14,
    S_LD     = 6'd2,  S_LDR    = 6'd6,  S_LDI1   = 6'd10, S_LDI2   = 6'd24,
    S_LDI3   = 6'd26, S_ST     = 6'd3,  S_STR    = 6'd7,  S_STI1   = 6'd11,
    S_STI2   = 6'd29, S_STI3   = 6'd31, S_MEM11  = 6'd25, S_MEM12  = 6'd27,
    S_MEM21  = 6'd23, S_MEM22  = 6'd16, S_TRAP1  = 6'd15, S_TRAP2  = 6'd28,
    S_TRAP3  = 6'd30, S_JSR    = 6'd4,  S_JSR0   = 6'd20, S_JSR1   = 6'd21,
    S_JMP    = 6'd12, S_BR2    = 6'd22
  } state_t;

  // Single-bit CTRL field positions; multi-bit fields are sliced inline.
  localparam int LD_MAR = 0,  LD_MDR = 1,  LD_IR = 2,  LD_PC = 3;
  localparam int LD_REG = 4,  LD_BEN = 5,  LD_CC = 6;
  localparam int G_MARMUX = 7, G_MDR = 8, G_ALU = 9, G_PC = 10;
  localparam int MARMUX = 11, ADDR1 = 12, CS = 19, WE = 20;

  // Wait counter must reach both the timeout limit and the last latency cycle.
  localparam int WAIT_MAX = (TIMEOUT > MEM_LAT) ? TIMEOUT : MEM_LAT;
  localparam int WCNT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] CNT_MAX  = WCNT_W'(WAIT_MAX);
  localparam logic [WCNT_W-1:0] LAT_LAST = WCNT_W'(MEM_LAT - 1);
  localparam logic [WCNT_W-1:0] TO_LIM   = WCNT_W'(TIMEOUT);

  state_t            state, state_nxt, wait_tgt;
  logic [WCNT_W-1:0] wait_cnt;
  logic              ben_q, ben_c;
  logic              is_wait, mem_done, timeout;
  logic              retire, bus_err, ill_op;
  logic [24:0]       c;
  logic              err_q;
  logic [CNT_W-1:0]  instret_q;
  logic              unused_sink;

  assign ben_c   = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
  assign is_wait = state inside {S_FETCH2, S_LDI2, S_STI2, S_MEM11, S_MEM22, S_TRAP2};
  assign mem_done = (MEM_MODE == 1) ? (wait_cnt == LAT_LAST) : READY;
  // READY in the limit cycle still completes the access.
  assign timeout = (MEM_MODE == 0) && (TIMEOUT > 0) && is_wait && !READY &&
                   (wait_cnt == TO_LIM);

  // Next state and event pulses.
  always_comb begin
    state_nxt = state;
    wait_tgt  = S_FETCH1;
    retire    = 1'b0;
    bus_err   = 1'b0;
    ill_op    = 1'b0;
    case (state)
      S_FETCH1: state_nxt = S_FETCH2;
      S_FETCH2: wait_tgt  = S_FETCH3;
      S_FETCH3: state_nxt = S_DECODE;
      S_DECODE: begin
        case (IR[15:12])
          4'h0: begin
            if (ben_c) state_nxt = S_BR2;
            else begin
              state_nxt = S_FETCH1;
              retire    = 1'b1;
            end
          end
          4'h1: state_nxt = S_ADD;
          4'h2: state_nxt = S_LD;
          4'h3: state_nxt = S_ST;
          4'h4: state_nxt = S_JSR;
          4'h5: state_nxt = S_AND;
          4'h6: state_nxt = S_LDR;
          4'h7: state_nxt = S_STR;
          4'h9: state_nxt = S_NOT;
          4'hA: state_nxt = S_LDI1;
          4'hB: state_nxt = S_STI1;
          4'hC: state_nxt = S_JMP;
          4'hE: state_nxt = S_LEA;
          4'hF: state_nxt = S_TRAP1;
          default: begin  // opcodes 8 and D
            state_nxt = S_FETCH1;
            ill_op    = 1'b1;
          end
        endcase
      end
      S_ADD, S_AND, S_NOT, S_LEA, S_JMP, S_JSR0, S_JSR1, S_BR2,
      S_MEM12, S_TRAP3: begin
        state_nxt = S_FETCH1;
        retire    = 1'b1;
      end
      S_LD, S_LDR, S_LDI3: state_nxt = S_MEM11;
      S_LDI1:              state_nxt = S_LDI2;
      S_ST, S_STR, S_STI3: state_nxt = S_MEM21;
      S_STI1:              state_nxt = S_STI2;
      S_MEM21:             state_nxt = S_MEM22;
      S_TRAP1:             state_nxt = S_TRAP2;
      S_JSR:               state_nxt = IR[11] ? S_JSR1 : S_JSR0;
      S_LDI2:              wait_tgt  = S_LDI3;
      S_STI2:              wait_tgt  = S_STI3;
      S_MEM11:             wait_tgt  = S_MEM12;
      S_MEM22:             wait_tgt  = S_FETCH1;
      S_TRAP2:             wait_tgt  = S_TRAP3;
      default:             state_nxt = S_FETCH1;
    endcase
    if (is_wait) begin
      if (timeout) begin
        state_nxt = S_FETCH1;
        bus_err   = 1'b1;
      end else if (mem_done) begin
        state_nxt = wait_tgt;
        retire    = (wait_tgt == S_FETCH1);
      end
    end
  end

  // Control word decode.
  always_comb begin
    c = '0;
    case (state)
      S_FETCH1: begin c[LD_MAR] = 1'b1; c[G_PC] = 1'b1; c[LD_PC] = 1'b1; end
      S_FETCH2, S_LDI2, S_STI2, S_MEM11: begin
        c[CS] = 1'b1; c[LD_MDR] = mem_done;
      end
      S_FETCH3: begin c[LD_IR] = 1'b1; c[G_MDR] = 1'b1; end
      S_DECODE: c[LD_BEN] = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        c[LD_REG] = 1'b1; c[18:17] = 2'd1; c[G_ALU] = 1'b1; c[LD_CC] = 1'b1;
        c[22:21] = (state == S_AND) ? 2'd1 : (state == S_NOT) ? 2'd2 : 2'd0;
      end
      S_LEA: begin
        c[LD_REG] = 1'b1; c[14:13] = 2'd2; c[MARMUX] = 1'b1;
        c[G_MARMUX] = 1'b1; c[LD_CC] = 1'b1;
      end
      S_LD, S_LDI1, S_ST, S_STI1: begin
        c[LD_MAR] = 1'b1; c[14:13] = 2'd2; c[MARMUX] = 1'b1; c[G_MARMUX] = 1'b1;
      end
      S_LDR, S_STR: begin
        c[LD_MAR] = 1'b1; c[18:17] = 2'd1; c[ADDR1] = 1'b1; c[14:13] = 2'd1;
        c[MARMUX] = 1'b1; c[G_MARMUX] = 1'b1;
      end
      S_LDI3, S_STI3: begin c[G_MDR] = 1'b1; c[LD_MAR] = 1'b1; end
      S_MEM12: begin c[G_MDR] = 1'b1; c[LD_REG] = 1'b1; c[LD_CC] = 1'b1; end
      S_MEM21: begin c[22:21] = 2'd3; c[G_ALU] = 1'b1; c[LD_MDR] = 1'b1; end
      S_MEM22: begin c[CS] = 1'b1; c[WE] = 1'b1; end
      S_TRAP1: begin c[G_MARMUX] = 1'b1; c[LD_MAR] = 1'b1; end
      S_TRAP2: begin
        c[CS] = 1'b1; c[24:23] = 2'd1; c[G_PC] = 1'b1;
        c[LD_MDR] = mem_done; c[LD_REG] = mem_done;
      end
      S_TRAP3: begin c[G_MDR] = 1'b1; c[16:15] = 2'd1; c[LD_PC] = 1'b1; end
      S_JSR: begin c[G_PC] = 1'b1; c[24:23] = 2'd1; c[LD_REG] = 1'b1; end
      S_JSR0, S_JMP: begin
        c[18:17] = 2'd1; c[ADDR1] = 1'b1; c[16:15] = 2'd2; c[LD_PC] = 1'b1;
      end
      S_JSR1: begin c[14:13] = 2'd3; c[16:15] = 2'd2; c[LD_PC] = 1'b1; end
      S_BR2:  begin c[14:13] = 2'd2; c[16:15] = 2'd2; c[LD_PC] = 1'b1; end
      default: c = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_FETCH1;
      wait_cnt  <= '0;
      ben_q     <= 1'b0;
      err_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state <= state_nxt;
      // Only wait states hold; any transition restarts the count.
      if (state_nxt == state)
        wait_cnt <= (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + WCNT_W'(1);
      else
        wait_cnt <= '0;
      if (c[LD_BEN]) ben_q <= ben_c;
      if (bus_err || ill_op) err_q <= 1'b1;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // While RESET is held the datapath sees an all-quiet control word.
  assign CTRL       = RESET ? '0 : c;
  assign STATE      = state;
  assign INSTR_DONE = retire & ~RESET;
  assign BUS_ERR    = bus_err & ~RESET;
  assign ILL_OP     = ill_op & ~RESET;
  assign ERR_STICKY = err_q;
  assign INSTRET    = instret_q;

  // BEN is held for the datapath's branch logic; offset bits of IR are not
  // needed by the sequencer.
  assign unused_sink = ^{ben_q, IR[8:0]};

endmodule
